// File: rtl/scale_up64_stream.sv
// ---------------------------------------------------------------------------
// scale_up64_stream
//
// Streaming complex float32 up-scaler. Each sample's real and imaginary parts
// are multiplied by 2^SHIFT by adding SHIFT to the biased exponent. This
// undoes the divide-by-64 normalisation applied inside the radix-5 datapath.
// Samples move through a two-stage valid/ready pipeline with one global
// advance enable.
//
// Per-part rules:
//   exponent 255 (Inf/NaN)    : word passes through unchanged, no overflow
//   exponent 0 (zero/denormal): flushed to signed zero, no overflow
//   exponent + SHIFT >= 255   : overflow, output saturates (see below)
//   otherwise                 : exponent replaced by exponent + SHIFT
//
// Build option (macro SCALE_SAT_FINITE_EN):
//   defined   : an overflowing part becomes the largest finite value, s,FE,7FFFFF
//   undefined : an overflowing part becomes signed infinity,        s,FF,000000
//
// Parameters:
//   SHIFT  exponent increment, legal range 0..253 (default 6, i.e. x64)
//   CNT_W  width of the overflow counter
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input sample valid
//   in_ready   block can accept a sample this cycle (combinational)
//   in_re      real part, float32
//   in_img     imaginary part, float32
//   out_valid  output sample valid
//   out_ready  downstream accepts the output sample
//   out_re     scaled real part
//   out_img    scaled imaginary part
//   out_ovf    at least one part of the current output overflowed
//   cnt_clr    synchronous clear of ovf_count (wins over an increment)
//   ovf_count  number of delivered samples with out_ovf=1, saturating
// ---------------------------------------------------------------------------
module scale_up64_stream #(
  parameter int SHIFT = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_re,
  input  logic [31:0]      in_img,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_re,
  output logic [31:0]      out_img,
  output logic             out_ovf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_SPEC = 2'd2
  } cls_t;

  localparam logic [8:0] SHIFT_9 = 9'(SHIFT);

  logic             en;
  logic             s1_valid_reg;
  logic             out_valid_reg;
  logic             out_ovf_reg;
  logic [CNT_W-1:0] ovf_count_reg;

  // Whole pipeline advances together; an empty output stage never blocks.
  assign en       = !out_valid_reg || out_ready;
  assign in_ready = en;

  // One identical lane per part: gi=0 real, gi=1 imaginary.
  for (genvar gi = 0; gi < 2; gi++) begin : part
    logic [31:0] in_word;
    logic [31:0] s1_word_reg;
    logic [8:0]  s1_t_reg;
    cls_t        s1_cls_reg;
    logic [31:0] s2_word_reg;
    logic [31:0] res_next;
    logic        ovf_next;
    cls_t        cls_next;

    assign in_word = (gi == 0) ? in_re : in_img;

    always_comb begin
      cls_next = CLS_NORM;
      if (in_word[30:23] == 8'hFF) begin
        cls_next = CLS_SPEC;
      end else if (in_word[30:23] == 8'h00) begin
        cls_next = CLS_ZERO;
      end
    end

    // Final word from the stage-1 precomputed sum and class.
    always_comb begin
      res_next = s1_word_reg;
      ovf_next = 1'b0;
      case (s1_cls_reg)
        CLS_SPEC: res_next = s1_word_reg;
        CLS_ZERO: res_next = {s1_word_reg[31], 31'h0};
        default: begin
          if (s1_t_reg >= 9'd255) begin
            ovf_next = 1'b1;
`ifdef SCALE_SAT_FINITE_EN
            res_next = {s1_word_reg[31], 8'hFE, 23'h7FFFFF};
`else
            res_next = {s1_word_reg[31], 8'hFF, 23'h0};
`endif
          end else begin
            res_next = {s1_word_reg[31], s1_t_reg[7:0], s1_word_reg[22:0]};
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_word_reg <= 32'h0;
        s1_t_reg    <= 9'h0;
        s1_cls_reg  <= CLS_ZERO;
        s2_word_reg <= 32'h0;
      end else if (en) begin
        s1_word_reg <= in_word;
        s1_t_reg    <= {1'b0, in_word[30:23]} + SHIFT_9;
        s1_cls_reg  <= cls_next;
        s2_word_reg <= res_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_ovf_reg   <= 1'b0;
    end else if (en) begin
      s1_valid_reg  <= in_valid;
      out_valid_reg <= s1_valid_reg;
      out_ovf_reg   <= part[0].ovf_next | part[1].ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count_reg <= '0;
    end else if (cnt_clr) begin
      ovf_count_reg <= '0;
    end else if (out_valid_reg && out_ready && out_ovf_reg && (ovf_count_reg != '1)) begin
      ovf_count_reg <= ovf_count_reg + 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_re    = part[0].s2_word_reg;
  assign out_img   = part[1].s2_word_reg;
  assign out_ovf   = out_ovf_reg;
  assign ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_scale_up64_stream.sv
// ---------------------------------------------------------------------------
// tb_scale_up64_stream
//
// Directed self-checking bench for scale_up64_stream (SHIFT=6, CNT_W=16).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scale_up64_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re;
  logic [31:0] in_img;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re;
  logic [31:0] out_img;
  logic        out_ovf;
  logic        cnt_clr;
  logic [15:0] ovf_count;

  int checks = 0;
  int errors = 0;

`ifdef SCALE_SAT_FINITE_EN
  localparam logic [31:0] POS_OVF = 32'h7F7FFFFF;
`else
  localparam logic [31:0] POS_OVF = 32'h7F800000;
`endif

  scale_up64_stream #(.SHIFT(6), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_img   (out_img),
    .out_ovf   (out_ovf),
    .cnt_clr   (cnt_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample, then idle the input for one edge so it reaches the output.
  task automatic send_one(input logic [31:0] re, input logic [31:0] img);
    in_valid = 1'b1; in_re = re; in_img = img;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_re = 32'h0; in_img = 32'h0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || out_ovf !== 1'b0 || out_re !== 32'h0 || out_img !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ovf=%b re=%h img=%h, want 0 0 0 0",
               out_valid, out_ovf, out_re, out_img);
    end
    checks++;
    if (ovf_count !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_count_ready: count=%h ready=%b, want 0000 1", ovf_count, in_ready);
    end
    rst = 1'b0;
    step();
    $display("reset: valid=%b count=%h ready=%b", out_valid, ovf_count, in_ready);
  endtask

  task automatic test_basic();
    send_one(32'h3F800000, 32'hBF000000);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 32'h42800000 || out_img !== 32'hC2000000 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic: valid=%b re=%h img=%h ovf=%b, want 1 42800000 c2000000 0",
               out_valid, out_re, out_img, out_ovf);
    end
    $display("basic: re=%h img=%h ovf=%b", out_re, out_img, out_ovf);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_single: out_valid=%b after drain, want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    send_one(32'h7F000000, 32'h3F800000);
    checks++;
    if (out_valid !== 1'b1 || out_re !== POS_OVF || out_img !== 32'h42800000 || out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: valid=%b re=%h img=%h ovf=%b, want 1 %h 42800000 1",
               out_valid, out_re, out_img, out_ovf, POS_OVF);
    end
    step();
    checks++;
    if (ovf_count !== 16'd1) begin
      errors++;
      $display("FAIL overflow_count: count=%h, want 0001", ovf_count);
    end
    $display("overflow: re=%h count=%h", out_re, ovf_count);
  endtask

  task automatic test_specials();
    in_valid = 1'b1; in_re = 32'h00000001; in_img = 32'h80000001;
    step();
    in_re = 32'h7FC00000; in_img = 32'hFF800000;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_re !== 32'h00000000 || out_img !== 32'h80000000 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL specials_denorm: valid=%b re=%h img=%h ovf=%b, want 1 00000000 80000000 0",
               out_valid, out_re, out_img, out_ovf);
    end
    $display("specials denorm: re=%h img=%h", out_re, out_img);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_re !== 32'h7FC00000 || out_img !== 32'hFF800000 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL specials_infnan: valid=%b re=%h img=%h ovf=%b, want 1 7fc00000 ff800000 0",
               out_valid, out_re, out_img, out_ovf);
    end
    $display("specials inf/nan: re=%h img=%h", out_re, out_img);
    step();
    checks++;
    if (ovf_count !== 16'd1) begin
      errors++;
      $display("FAIL specials_count: count=%h, want 0001", ovf_count);
    end
  endtask

  // Eight samples with exponents 100..107 and mantissa = index; expected
  // exponents are 106..113 with the mantissa untouched.
  task automatic test_backpressure();
    logic [31:0] exp_re [8];
    logic [31:0] exp_img[8];
    logic        pat[6];
    int tx = 0;
    int rx = 0;
    int cyc = 0;
    logic hs_in, hs_out, stall;
    logic [31:0] hold_re, hold_img;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      exp_re[i]  = {1'b0, 8'(106 + i), 23'(i)};
      exp_img[i] = {1'b1, 8'(106 + i), 23'(i + 16)};
    end
    while (rx < 8 && cyc < 200) begin
      out_ready = pat[cyc % 6];
      in_valid  = (tx < 8);
      in_re     = {1'b0, 8'(100 + tx), 23'(tx)};
      in_img    = {1'b1, 8'(100 + tx), 23'(tx + 16)};
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      stall  = out_valid && !out_ready;
      hold_re  = out_re;
      hold_img = out_img;
      if (stall) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: in_ready=%b during stall, want 0", in_ready);
        end
      end
      if (hs_out) begin
        checks++;
        if (out_re !== exp_re[rx] || out_img !== exp_img[rx] || out_ovf !== 1'b0) begin
          errors++;
          $display("FAIL bp_data[%0d]: re=%h img=%h ovf=%b, want %h %h 0",
                   rx, out_re, out_img, out_ovf, exp_re[rx], exp_img[rx]);
        end
        $display("backpressure: out[%0d] re=%h img=%h", rx, out_re, out_img);
        rx++;
      end
      if (hs_in) tx++;
      step();
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_re !== hold_re || out_img !== hold_img) begin
          errors++;
          $display("FAIL bp_stable: valid=%b re=%h img=%h, want 1 %h %h",
                   out_valid, out_re, out_img, hold_re, hold_img);
        end
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (rx != 8) begin
      errors++;
      $display("FAIL bp_count: received %0d samples, want 8", rx);
    end
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: out_valid=%b after drain, want 0", out_valid);
    end
  endtask

  task automatic test_cnt_clr();
    in_valid = 1'b1; in_re = 32'h7F000000; in_img = 32'h3F800000;
    step();
    in_valid = 1'b0;
    step();
    cnt_clr = 1'b1;   // same edge as the overflowing handshake
    step();
    cnt_clr = 1'b0;
    checks++;
    if (ovf_count !== 16'h0) begin
      errors++;
      $display("FAIL cnt_clr_priority: count=%h, want 0000", ovf_count);
    end
    $display("cnt_clr: count=%h", ovf_count);
  endtask

  task automatic test_saturation();
    in_re = 32'hFF000000; in_img = 32'h7F000000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    in_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (ovf_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturation: count=%h, want ffff", ovf_count);
    end
    $display("saturation: count=%h", ovf_count);
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; in_re = 32'h7F000000; in_img = 32'h3F800000;
    step();
    in_re = 32'h3F800000;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || ovf_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b count=%h, want 0 0000", out_valid, ovf_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale: out_valid=%b cycle %0d after release, want 0", out_valid, i);
      end
    end
    $display("reset midstream: valid=%b count=%h", out_valid, ovf_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_specials();
    test_backpressure();
    test_cnt_clr();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
